// File: rtl/hash_request_sequencer.sv
// hash_request_sequencer: one-in-flight request front-end sequencing table read, controller evaluate and response
module hash_request_sequencer #(
  parameter int KEY_WIDTH        = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_TABLES = 3,
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [KEY_WIDTH-1:0]  req_key_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [1:0]            req_op_i,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  mem_read_en_o,
  output logic [1:0]            delete_write_read_o,
  input  logic [DATA_WIDTH-1:0] ctrl_read_data_i,
  input  logic                  ctrl_no_element_found_i,
  input  logic                  ctrl_key_already_present_i,
  input  logic                  ctrl_no_write_space_i,
  input  logic                  ctrl_no_deletion_target_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_op_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [2:0]            resp_status_o
);
  localparam int CW = $clog2(MEM_READ_LATENCY + 1);
  if (MEM_READ_LATENCY < 1 || NUMBER_OF_TABLES < 1) begin : g_bad_params
    $error("hash_request_sequencer: MEM_READ_LATENCY and NUMBER_OF_TABLES must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, READ, EVAL, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]  key_q, key_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            status_q, status_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  // next state, request latch and status capture; only flags relevant to the latched op count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    data_d   = data_q;
    op_d     = op_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (req_valid_i && req_op_i != 2'b00) begin
        key_d   = req_key_i;
        data_d  = req_data_i;
        op_d    = req_op_i;
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(MEM_READ_LATENCY - 1)) ? EVAL : READ;
      end
      EVAL: begin
        status_d = (op_q == 2'b01 && ctrl_no_element_found_i)    ? 3'b001 :
                   (op_q == 2'b10 && ctrl_key_already_present_i) ? 3'b010 :
                   (op_q == 2'b10 && ctrl_no_write_space_i)      ? 3'b011 :
                   (op_q == 2'b11 && ctrl_no_deletion_target_i)  ? 3'b100 : 3'b000;
        rdata_d  = (op_q == 2'b01 && status_d == 3'b000) ? ctrl_read_data_i : '0;
        state_d  = RESP;
      end
      default: state_d = resp_ready_i ? IDLE : RESP;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      data_q   <= '0;
      op_q     <= 2'b00;
      status_q <= 3'b000;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      data_q   <= data_d;
      op_q     <= op_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end
  assign req_ready_o         = state_q == IDLE;
  assign mem_read_en_o       = state_q == READ && cnt_q == '0;
  assign delete_write_read_o = state_q == EVAL ? op_q : 2'b00;
  assign resp_valid_o        = state_q == RESP;
  assign key_o               = key_q;
  assign data_o              = data_q;
  assign resp_op_o           = op_q;
  assign resp_data_o         = rdata_q;
  assign resp_status_o       = status_q;
endmodule
